// File: rtl/maze_pkg.sv
// Shared types and constants for the maze game's elapsed-time display path.
package maze_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALT} timer_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] BCD_ZERO = 8'h00;

endpackage

// File: rtl/bcd2_inc.sv
// Combinational two-digit packed BCD incrementer {tens, units}; 99 wraps to 00.
module bcd2_inc
  import maze_pkg::*;
(
  input  logic [7:0] i_value,
  output logic [7:0] o_value
);

  bcd_digit_t w_tens;
  bcd_digit_t w_units;

  always_comb begin
    w_tens  = i_value[7:4];
    w_units = i_value[3:0];
    if (w_units == 4'd9) begin
      o_value = {((w_tens == 4'd9) ? 4'd0 : w_tens + 4'd1), 4'd0};
    end else begin
      o_value = {w_tens, w_units + 4'd1};
    end
  end

endmodule

// File: rtl/maze_bcd_timer.sv
// Game elapsed-time counter: prescaled tick, two-digit BCD count with
// start/pause/finish/clear control and saturation at LIMIT_BCD.
module maze_bcd_timer #(
  parameter int          TICK_DIV  = 1000000,
  parameter logic [7:0]  LIMIT_BCD = 8'h99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       finish,
  input  logic       clear,
  output logic [7:0] number,
  output logic       running,
  output logic       expired
);

  import maze_pkg::*;

  localparam int              PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  timer_state_t     r_state;
  timer_state_t     w_state_nxt;
  logic [PRE_W-1:0] r_pre;
  logic [PRE_W-1:0] w_pre_nxt;
  logic [7:0]       r_number;
  logic [7:0]       w_number_nxt;
  logic [7:0]       w_number_inc;
  logic             r_running;
  logic             r_expired;
  logic             w_expired_nxt;
  logic             w_tick;

  bcd2_inc u_inc (
    .i_value (r_number),
    .o_value (w_number_inc)
  );

  assign w_tick = (r_state == RUN) && (r_pre == PRE_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_pre_nxt     = r_pre;
    w_number_nxt  = r_number;
    w_expired_nxt = 1'b0;

    if (clear) begin
      w_state_nxt  = IDLE;
      w_pre_nxt    = '0;
      w_number_nxt = BCD_ZERO;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_state_nxt = RUN;
            w_pre_nxt   = '0;
          end
        end
        RUN: begin
          // finish/pause win over a coincident tick, which is then dropped
          if (finish) begin
            w_state_nxt = HALT;
          end else if (pause) begin
            w_state_nxt = PAUSE;
          end else if (w_tick) begin
            w_pre_nxt    = '0;
            w_number_nxt = w_number_inc;
            if (w_number_inc == LIMIT_BCD) begin
              w_state_nxt   = HALT;
              w_expired_nxt = 1'b1;
            end
          end else begin
            w_pre_nxt = r_pre + PRE_W'(1);
          end
        end
        PAUSE: begin
          if (finish) begin
            w_state_nxt = HALT;
          end else if (!pause && start) begin
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_state_nxt = HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pre     <= '0;
      r_number  <= BCD_ZERO;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre     <= w_pre_nxt;
      r_number  <= w_number_nxt;
      r_running <= (w_state_nxt == RUN);
      r_expired <= w_expired_nxt;
    end
  end

  assign number  = r_number;
  assign running = r_running;
  assign expired = r_expired;

endmodule

// File: tb/tb_maze_bcd_timer.sv
// Bench for maze_bcd_timer: two instances (limit 99 and limit 12) share stimulus
// and are compared every cycle against a decimal-count reference model.
module tb_maze_bcd_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       finish = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] a_number, b_number;
  logic       a_running, b_running;
  logic       a_expired, b_expired;

  int tests = 0;
  int fails = 0;

  // reference model: mode 0 idle, 1 counting, 2 paused, 3 stopped
  int m_mode[2];
  int m_cnt[2];
  int m_pre[2];
  bit m_exp[2];
  int m_lim[2] = '{99, 12};

  always #5 clk = ~clk;

  maze_bcd_timer #(.TICK_DIV(TD), .LIMIT_BCD(8'h99)) u_a (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .finish(finish),
    .clear(clear), .number(a_number), .running(a_running), .expired(a_expired)
  );

  maze_bcd_timer #(.TICK_DIV(TD), .LIMIT_BCD(8'h12)) u_b (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .finish(finish),
    .clear(clear), .number(b_number), .running(b_running), .expired(b_expired)
  );

  function automatic logic [7:0] to_bcd(input int c);
    logic [3:0] t, u;
    t = 4'(c / 10);
    u = 4'(c % 10);
    return {t, u};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic s, input logic p, input logic f,
                            input logic c, input logic r);
    for (int k = 0; k < 2; k++) begin
      m_exp[k] = 1'b0;
      if (r || c) begin
        m_mode[k] = 0; m_cnt[k] = 0; m_pre[k] = 0;
      end else if (m_mode[k] == 0) begin
        if (s) begin m_mode[k] = 1; m_pre[k] = 0; end
      end else if (m_mode[k] == 1) begin
        if (f) m_mode[k] = 3;
        else if (p) m_mode[k] = 2;
        else begin
          m_pre[k] = (m_pre[k] + 1) % TD;
          if (m_pre[k] == 0) begin
            m_cnt[k] = m_cnt[k] + 1;
            if (m_cnt[k] == m_lim[k]) begin m_mode[k] = 3; m_exp[k] = 1'b1; end
          end
        end
      end else if (m_mode[k] == 2) begin
        if (f) m_mode[k] = 3;
        else if (!p && s) m_mode[k] = 1;
      end
    end
  endtask

  task automatic check_models();
    chk("a_number",  a_number, to_bcd(m_cnt[0]));
    chk("a_running", {7'd0, a_running}, {7'd0, m_mode[0] == 1});
    chk("a_expired", {7'd0, a_expired}, {7'd0, m_exp[0]});
    chk("a_units_bcd", {7'd0, a_number[3:0] <= 4'd9}, 8'd1);
    chk("b_number",  b_number, to_bcd(m_cnt[1]));
    chk("b_running", {7'd0, b_running}, {7'd0, m_mode[1] == 1});
    chk("b_expired", {7'd0, b_expired}, {7'd0, m_exp[1]});
  endtask

  task automatic step(input logic s, input logic p, input logic f,
                      input logic c, input logic r);
    start = s; pause = p; finish = f; clear = c; rst = r;
    @(posedge clk);
    model_edge(s, p, f, c, r);
    #1;
    check_models();
  endtask

  task automatic wait_pre(input int target, input string tag);
    int guard;
    guard = 0;
    while (m_pre[0] != target && guard < 2 * TD) begin
      step(0, 0, 0, 0, 0);
      guard++;
    end
    if (m_pre[0] != target) begin
      tests++;
      fails++;
      $error("FAIL %s: prescaler wait expired, observed pre %0d expected %0d", tag, m_pre[0], target);
    end
  endtask

  initial begin
    int held;
    logic [7:0] held_bcd;

    // reset for two cycles
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset_number", a_number, 8'h00);
    chk("reset_running", {7'd0, a_running}, 8'd0);
    chk("reset_expired", {7'd0, b_expired}, 8'd0);

    // basic count, digit carry, saturation of the limit-12 instance
    step(1, 0, 0, 0, 0);
    chk("start_running", {7'd0, a_running}, 8'd1);
    for (int e = 1; e <= 48; e++) begin
      step(0, 0, 0, 0, 0);
      if (e == 3)  chk("basic_e3", a_number, 8'h00);
      if (e == 4)  chk("basic_e4", a_number, 8'h01);
      if (e == 8)  chk("basic_e8", a_number, 8'h02);
      if (e == 36) chk("carry_09", a_number, 8'h09);
      if (e == 40) chk("carry_10", a_number, 8'h10);
      if (e == 44) chk("carry_11", a_number, 8'h11);
      if (e < 48)  chk("b_no_expire", {7'd0, b_expired}, 8'd0);
    end
    chk("sat_number", b_number, 8'h12);
    chk("sat_expired", {7'd0, b_expired}, 8'd1);
    chk("sat_running", {7'd0, b_running}, 8'd0);
    chk("a_not_expired", {7'd0, a_expired}, 8'd0);
    for (int e = 49; e <= 88; e++) begin
      step(1, 0, 0, 0, 0);
      if (e == 49) chk("sat_expired_fall", {7'd0, b_expired}, 8'd0);
      chk("sat_hold", b_number, 8'h12);
    end
    chk("a_after_88", a_number, 8'h22);

    // pause with pre = 2, hold, resume
    wait_pre(2, "pause_wait");
    step(0, 1, 0, 0, 0);
    held = m_cnt[0];
    held_bcd = a_number;
    chk("paused_running", {7'd0, a_running}, 8'd0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, 0);
      chk("pause_hold", a_number, held_bcd);
    end
    step(1, 0, 0, 0, 0);
    chk("resume_running", {7'd0, a_running}, 8'd1);
    step(0, 0, 0, 0, 0);
    chk("resume_e1", a_number, to_bcd(held));
    step(0, 0, 0, 0, 0);
    chk("resume_e2", a_number, to_bcd(held + 1));

    // simultaneous events
    step(1, 1, 0, 0, 0);
    chk("pause_start_run", {7'd0, a_running}, 8'd0);
    step(1, 0, 0, 0, 0);
    chk("restart_running", {7'd0, a_running}, 8'd1);
    wait_pre(TD - 1, "finish_wait");
    held_bcd = a_number;
    step(0, 0, 1, 0, 0);
    chk("finish_tick_number", a_number, held_bcd);
    chk("finish_tick_running", {7'd0, a_running}, 8'd0);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0);
    chk("halt_frozen", a_number, held_bcd);
    step(1, 0, 0, 1, 0);
    chk("clear_start_a", a_number, 8'h00);
    chk("clear_start_b", b_number, 8'h00);
    chk("clear_start_run", {7'd0, a_running}, 8'd0);

    // reset mid-run at count 37, pre 3
    step(1, 0, 0, 0, 0);
    for (int e = 1; e <= 151; e++) step(0, 0, 0, 0, 0);
    chk("pre_rst_count", a_number, 8'h37);
    step(0, 0, 0, 0, 1);
    chk("midrst_number", a_number, 8'h00);
    chk("midrst_running", {7'd0, a_running}, 8'd0);
    chk("midrst_expired", {7'd0, a_expired}, 8'd0);
    step(1, 0, 0, 0, 0);
    for (int e = 1; e <= 4; e++) begin
      step(0, 0, 0, 0, 0);
      if (e == 3) chk("post_rst_e3", a_number, 8'h00);
      if (e == 4) chk("post_rst_e4", a_number, 8'h01);
    end

    // randomized control traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 149) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/maze_bcd_timer.md
# maze_bcd_timer

Elapsed-time source for the maze game's two-digit display. Divides the system clock down to a game tick and counts ticks as a two-digit packed BCD value, 00 to LIMIT_BCD. Start, pause, finish and clear controls come from the game controller. The 8-bit `number` output connects directly to the seven-segment driver's `number` input: high nibble is the tens digit, low nibble the units digit.

## Interface
- `TICK_DIV`, default 1000000: clk cycles per count tick; must be ≥ 2.
- `LIMIT_BCD`, default 8'h99: terminal count; must be valid packed BCD and ≥ 8'h01.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  level-sampled; starts the timer from IDLE or resumes it from PAUSE.
- `pause`  in  1  level-sampled; freezes the timer while in RUN.
- `finish`  in  1  level-sampled; stops the timer permanently (goal reached).
- `clear`  in  1  level-sampled; returns the block to IDLE with the count at 00.
- `number`  out  8  packed BCD count {tens, units}.
- `running`  out  1  registered; high iff the state is RUN.
- `expired`  out  1  one-cycle pulse when the count reaches LIMIT_BCD.

## Operation
- States: IDLE, RUN, PAUSE, HALT.
- Prescaler `pre` counts 0..TICK_DIV-1.
- A tick occurs when state is RUN and `pre` == TICK_DIV-1; `pre` then wraps to 0.
- Input priority each edge: `rst` > `clear` > `finish` > `pause` > `start`.
- `rst` or `clear`, from any state:
  - state IDLE, `number` 8'h00, `pre` 0, `expired` 0.
- IDLE:
  - `start` → RUN, `pre` 0.
  - `pause` and `finish` are ignored; `number` holds.
- RUN:
  - `finish` → HALT; `pause` → PAUSE.
  - In either case, a tick falling in that same cycle is discarded: `number` and `pre` hold.
  - Otherwise `pre` advances, and on a tick `number` takes the BCD increment:
    - units 9 → 0 with carry into tens;
    - tens and units are always valid digits 0–9.
  - If the incremented value equals LIMIT_BCD: `number` becomes LIMIT_BCD, state → HALT, and `expired` is high for that one cycle.
- PAUSE:
  - `pre` and `number` hold.
  - `start` → RUN; `pre` resumes from its held value and is not reset.
  - `finish` → HALT.
- HALT:
  - `number` frozen; `start`, `pause` and `finish` are ignored.
  - Only `clear` or `rst` leaves HALT.
- Wrap-around never occurs; the count saturates at LIMIT_BCD because HALT is entered there.
- The count never contains an invalid BCD digit.

## Timing
- Reset values: `number` 8'h00, `running` 0, `expired` 0, state IDLE, `pre` 0.
- Every output is registered; no combinational path from any input to any output.
- First count:
  - `start` sampled at edge E0 means `running` = 1 after E0.
  - The first increment lands at edge E0 + TICK_DIV; each later one every TICK_DIV cycles.
- Pause/resume:
  - `pause` sampled at edge Ep with `pre` = k means `pre` holds k.
  - Resume at edge Er gives the next increment at edge Er + (TICK_DIV-1-k) + 1.
- `expired` rises on the same edge that `number` becomes LIMIT_BCD and falls on the next edge.
- `clear` or `rst` in mid-operation takes effect on the sampling edge; any tick in that cycle is discarded.

## Structure
- Shared package `maze_pkg`:
  - `timer_state_t` enum {IDLE, RUN, PAUSE, HALT};
  - `bcd_digit_t` (4-bit) typedef;
  - constant `BCD_ZERO` = 8'h00.
- One sub-module, `bcd2_inc`: combinational two-digit BCD incrementer, 8-bit in → 8-bit out.
  - Instantiated once; reusable by the step counter.
- Top level contains the FSM, the prescaler and the output registers.

## Test plan
All scenarios use `TICK_DIV` = 4 unless noted.
- **Basic count:** `rst` for 2 cycles, then `start` at edge 0.
  - Required: `running` = 1 after edge 0; `number` 8'h01 at edge 4, 8'h02 at edge 8; `expired` stays 0.
- **Digit carry:** let the count run from 8'h08.
  - Required: 8'h09, then 8'h10, then 8'h11; a low nibble of A–F never appears.
- **Saturation (`LIMIT_BCD` = 8'h12):**
  - Required: `number` reaches 8'h12 with `expired` high for exactly 1 cycle, `running` drops, and the count stays 8'h12 for 40 further cycles despite `start` being held high.
- **Pause/resume:** pause while `pre` = 2, hold 10 cycles, then assert `start`.
  - Required: `number` is unchanged during the pause; the next increment lands 2 edges after the resume edge.
- **Simultaneous events:**
  - `finish` on a tick cycle → HALT with no increment.
  - `clear` together with `start` → IDLE, `number` 8'h00, `running` 0.
  - `pause` together with `start` in RUN → PAUSE.
- **Reset mid-run:** assert `rst` at count 8'h37 with `pre` = 3.
  - Required: after that edge `number` = 8'h00, `running` = 0, `expired` = 0, and the first count after a new `start` follows the 4-cycle latency.
